// File: rtl/uart_rx_fifo_if.sv
// Byte-stream and status bundle between a UART receiver, the RX FIFO and its consumer.
// slave is the FIFO side; master is the receiver/consumer side driving it.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                     rx_done;
  logic [7:0]               rx_data;
  logic                     rx_error;
  logic                     rd_ready;
  logic                     clr_status;
  logic                     rd_valid;
  logic [7:0]               rd_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic [ERR_CNT_W-1:0]     frame_err_cnt;

  modport slave (
    input  rx_done, rx_data, rx_error, rd_ready, clr_status,
    output rd_valid, rd_data, count, full, empty, overflow, frame_err_cnt
  );

  modport master (
    output rx_done, rx_data, rx_error, rd_ready, clr_status,
    input  rd_valid, rd_data, count, full, empty, overflow, frame_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind a UART receiver, with sticky overflow
// and a saturating framing-error counter.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          cnt;
  logic                 ovf;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 rx_error_q;

  logic is_full;
  logic is_empty;
  logic wr_en;
  logic rd_en;
  logic drop;
  logic frame_evt;

  always_comb begin
    is_full   = (cnt == (AW+1)'(DEPTH));
    is_empty  = (cnt == '0);
    rd_en     = !is_empty && bus.rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en     = bus.rx_done && (!is_full || rd_en);
    drop      = bus.rx_done && !wr_en;
    frame_evt = bus.rx_error && !rx_error_q;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Status events take priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf        <= 1'b0;
      err_cnt    <= '0;
      rx_error_q <= 1'b0;
    end else begin
      rx_error_q <= bus.rx_error;

      if (drop) begin
        ovf <= 1'b1;
      end else if (bus.clr_status) begin
        ovf <= 1'b0;
      end

      if (frame_evt) begin
        if (bus.clr_status) begin
          err_cnt <= ERR_CNT_W'(1);
        end else if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end else if (bus.clr_status) begin
        err_cnt <= '0;
      end
    end
  end

  always_comb begin
    bus.rd_valid      = !is_empty;
    bus.rd_data       = is_empty ? 8'h00 : mem[rd_ptr];
    bus.count         = cnt;
    bus.full          = is_full;
    bus.empty         = is_empty;
    bus.overflow      = ovf;
    bus.frame_err_cnt = err_cnt;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

  logic clk = 1'b0;
  logic rst;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  byte unsigned m_q[$];
  bit           m_ovf;
  int           m_err;
  bit           m_rxe_prev;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rd, wr;
    if (rst) begin
      m_q.delete();
      m_ovf      = 0;
      m_err      = 0;
      m_rxe_prev = 0;
    end else begin
      rd = (m_q.size() > 0) && bus.rd_ready;
      wr = bus.rx_done && ((m_q.size() < DEPTH) || rd);
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(bus.rx_data);
      if (bus.clr_status) begin
        m_ovf = 0;
        m_err = 0;
      end
      if (bus.rx_done && !wr) m_ovf = 1;
      if (bus.rx_error && !m_rxe_prev && m_err < ERR_MAX) m_err++;
      m_rxe_prev = bus.rx_error;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
    check_eq("rd_data",  32'(bus.rd_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    check_eq("count",    32'(bus.count),    32'(m_q.size()));
    check_eq("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
    check_eq("empty",    32'(bus.empty),    32'(m_q.size() == 0));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("err_cnt",  32'(bus.frame_err_cnt), 32'(m_err));
  endtask

  task automatic drive(input bit r, input bit done, input byte unsigned data,
                       input bit err, input bit rdy, input bit clr);
    rst            = r;
    bus.rx_done    = done;
    bus.rx_data    = data;
    bus.rx_error   = err;
    bus.rd_ready   = rdy;
    bus.clr_status = clr;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_done = 0; bus.rx_data = '0; bus.rx_error = 0;
    bus.rd_ready = 0; bus.clr_status = 0;

    // Reset state, with other inputs active to show reset dominance
    drive(1, 1, 8'h77, 1, 1, 1);
    check_eq("rst_empty", 32'(bus.empty), 32'h1);
    check_eq("rst_data",  32'(bus.rd_data), 32'h0);

    // Two writes, one read
    drive(0, 1, 8'hA5, 0, 0, 0);
    drive(0, 1, 8'h3C, 0, 0, 0);
    check_eq("two_count", 32'(bus.count), 32'd2);
    check_eq("two_head",  32'(bus.rd_data), 32'hA5);
    drive(0, 0, 8'h00, 0, 1, 0);
    check_eq("pop_head",  32'(bus.rd_data), 32'h3C);
    check_eq("pop_count", 32'(bus.count), 32'd1);
    drive(0, 0, 8'h00, 0, 1, 0);
    drive(0, 0, 8'h00, 0, 1, 0);  // read while empty: no effect

    // Overfill then drain in order
    do_reset();
    for (int i = 0; i <= 16; i++) drive(0, 1, 8'(i), 0, 0, 0);
    check_eq("ovf_full",  32'(bus.full), 32'h1);
    check_eq("ovf_count", 32'(bus.count), 32'd16);
    check_eq("ovf_flag",  32'(bus.overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_order", 32'(bus.rd_data), 32'(i));
      drive(0, 0, 8'h00, 0, 1, 0);
    end
    check_eq("drain_empty", 32'(bus.empty), 32'h1);

    // Full with simultaneous read and write
    do_reset();
    for (int i = 0; i < 16; i++) drive(0, 1, 8'(8'h10 + i), 0, 0, 0);
    drive(0, 1, 8'hEE, 0, 1, 0);
    check_eq("rw_full_count", 32'(bus.count), 32'd16);
    check_eq("rw_full_ovf",   32'(bus.overflow), 32'h0);
    for (int i = 0; i < 15; i++) drive(0, 0, 8'h00, 0, 1, 0);
    check_eq("rw_last_byte", 32'(bus.rd_data), 32'hEE);
    drive(0, 0, 8'h00, 0, 1, 0);
    // Empty with read+write: only the write fires
    drive(0, 1, 8'h42, 0, 1, 0);
    check_eq("empty_rw_count", 32'(bus.count), 32'd1);

    // Framing errors
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 0);
    check_eq("ferr_two", 32'(bus.frame_err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 8'h00, 1, 0, 0);
      drive(0, 0, 8'h00, 0, 0, 0);
    end
    check_eq("ferr_sat", 32'(bus.frame_err_cnt), 32'd255);

    // Clear racing an event, then clear alone
    drive(0, 0, 8'h00, 1, 0, 1);
    check_eq("clr_evt_wins", 32'(bus.frame_err_cnt), 32'd1);
    drive(0, 0, 8'h00, 0, 0, 1);
    check_eq("clr_cnt",  32'(bus.frame_err_cnt), 32'd0);
    check_eq("clr_ovf",  32'(bus.overflow), 32'h0);

    // Overflow racing a clear
    do_reset();
    for (int i = 0; i < 16; i++) drive(0, 1, 8'(i), 0, 0, 0);
    drive(0, 1, 8'h99, 0, 0, 1);
    check_eq("clr_ovf_wins", 32'(bus.overflow), 32'h1);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 1, 8'(8'hC0 + i), 0, 0, 0);
    drive(1, 1, 8'hFF, 0, 0, 0);
    check_eq("mid_rst_empty", 32'(bus.empty), 32'h1);
    check_eq("mid_rst_count", 32'(bus.count), 32'd0);
    check_eq("mid_rst_data",  32'(bus.rd_data), 32'h0);
    drive(0, 1, 8'h5A, 0, 0, 0);
    check_eq("post_rst_data",  32'(bus.rd_data), 32'h5A);
    check_eq("post_rst_count", 32'(bus.count), 32'd1);

    // rx_error already high when reset releases
    drive(1, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    check_eq("rel_err", 32'(bus.frame_err_cnt), 32'd1);
    idle(2);

    // Randomized traffic
    begin
      bit err_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) err_lvl = ~err_lvl;
        drive(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 55),
              8'($urandom),
              err_lvl,
              ($urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 60)),
              ($urandom_range(0, 39) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
